// File: rtl/pipe_ctrl.sv
// Y86-style pipeline hazard controller: load-use, mispredict, ret and halt handling.
// Optional performance counters are enabled by defining PIPE_CTRL_PERF_CNT_EN.
module pipe_ctrl (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [3:0]  D_icode_i,
  input  logic [3:0]  d_srcA_i,
  input  logic [3:0]  d_srcB_i,
  input  logic [3:0]  E_icode_i,
  input  logic [3:0]  E_dstM_i,
  input  logic        e_Cnd_i,
  input  logic [3:0]  m_stat_i,
  input  logic [3:0]  W_stat_i,
  input  logic        cnt_clr_i,
  output logic        F_stall_o,
  output logic        D_stall_o,
  output logic        D_bubble_o,
  output logic        E_bubble_o,
  output logic        M_bubble_o,
  output logic        W_stall_o,
  output logic        halted_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] bubble_cnt_o,
  output logic [31:0] mispred_cnt_o,
  output logic [31:0] ret_cnt_o
);

  // Encodings shared with define.v
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [3:0] RNONE   = 4'hF;
  localparam logic [3:0] SAOK    = 4'h1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RET_E = 2'd1,
    S_RET_M = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  state_e state_q, state_d;
  logic   load_use, mispred, w_bad, m_bad;
  logic   ret_evt, mp_evt;

  assign load_use = ((E_icode_i == IMRMOVQ) || (E_icode_i == IPOPQ)) &&
                    (E_dstM_i != RNONE) &&
                    ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
  assign mispred  = (E_icode_i == IJXX) && !e_Cnd_i;
  assign w_bad    = (W_stat_i != SAOK);
  assign m_bad    = (m_stat_i != SAOK);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    F_stall_o  = 1'b0;
    D_stall_o  = 1'b0;
    D_bubble_o = 1'b0;
    E_bubble_o = 1'b0;
    M_bubble_o = 1'b0;
    W_stall_o  = 1'b0;
    ret_evt    = 1'b0;
    mp_evt     = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Priority: mispredict squashes everything, then load-use, then ret.
        if (mispred) begin
          D_bubble_o = 1'b1;
          E_bubble_o = 1'b1;
          mp_evt     = 1'b1;
        end else if (load_use) begin
          F_stall_o  = 1'b1;
          D_stall_o  = 1'b1;
          E_bubble_o = 1'b1;
        end else if (D_icode_i == IRET) begin
          F_stall_o  = 1'b1;
          D_bubble_o = 1'b1;
          ret_evt    = 1'b1;
          state_d    = S_RET_E;
        end
      end
      S_RET_E: begin
        F_stall_o  = 1'b1;
        D_bubble_o = 1'b1;
        state_d    = S_RET_M;
      end
      S_RET_M: begin
        F_stall_o  = 1'b1;
        D_bubble_o = 1'b1;
        state_d    = S_IDLE;
      end
      S_HALT: begin
        F_stall_o  = 1'b1;
        D_stall_o  = 1'b1;
        W_stall_o  = 1'b1;
        M_bubble_o = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (m_bad || w_bad) M_bubble_o = 1'b1;
    // A faulting writeback abandons any ret sequence and parks the pipeline.
    if (w_bad) begin
      W_stall_o = 1'b1;
      state_d   = S_HALT;
    end
  end

  assign halted_o = (state_q == S_HALT);

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [3:0]  cnt_inc;
  logic [31:0] cnt_out [4];

  assign cnt_inc = {ret_evt, mp_evt, (D_bubble_o | E_bubble_o | M_bubble_o), F_stall_o};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
      logic [31:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr_i)
          cnt_d = 32'h0;
        else if (cnt_inc[gi] && (state_q != S_HALT) && (cnt_q != 32'hFFFF_FFFF))
          cnt_d = cnt_q + 32'd1;
      end

      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) cnt_q <= 32'h0;
        else          cnt_q <= cnt_d;
      end

      assign cnt_out[gi] = cnt_q;
    end
  endgenerate

  assign stall_cnt_o   = cnt_out[0];
  assign bubble_cnt_o  = cnt_out[1];
  assign mispred_cnt_o = cnt_out[2];
  assign ret_cnt_o     = cnt_out[3];
`else
  logic unused_perf;
  assign unused_perf   = ^{cnt_clr_i, ret_evt, mp_evt};
  assign stall_cnt_o   = 32'h0;
  assign bubble_cnt_o  = 32'h0;
  assign mispred_cnt_o = 32'h0;
  assign ret_cnt_o     = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: ret, load-use, mispredict, halt, reset and counter behaviour.
// Counter expectations follow whether PIPE_CTRL_PERF_CNT_EN is defined for the build.
module tb_pipe_ctrl;

  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [3:0] RNONE   = 4'hF;
  localparam logic [3:0] SAOK    = 4'h1;
  localparam logic [3:0] SADR    = 4'h3;
  localparam logic [3:0] SINS    = 4'h4;
`ifdef PIPE_CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [3:0]  D_icode_i, d_srcA_i, d_srcB_i, E_icode_i, E_dstM_i, m_stat_i, W_stat_i;
  logic        e_Cnd_i, cnt_clr_i;
  logic        F_stall_o, D_stall_o, D_bubble_o, E_bubble_o, M_bubble_o, W_stall_o, halted_o;
  logic [31:0] stall_cnt_o, bubble_cnt_o, mispred_cnt_o, ret_cnt_o;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  pipe_ctrl dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .D_icode_i(D_icode_i), .d_srcA_i(d_srcA_i), .d_srcB_i(d_srcB_i),
    .E_icode_i(E_icode_i), .E_dstM_i(E_dstM_i), .e_Cnd_i(e_Cnd_i),
    .m_stat_i(m_stat_i), .W_stat_i(W_stat_i), .cnt_clr_i(cnt_clr_i),
    .F_stall_o(F_stall_o), .D_stall_o(D_stall_o), .D_bubble_o(D_bubble_o),
    .E_bubble_o(E_bubble_o), .M_bubble_o(M_bubble_o), .W_stall_o(W_stall_o),
    .halted_o(halted_o), .stall_cnt_o(stall_cnt_o), .bubble_cnt_o(bubble_cnt_o),
    .mispred_cnt_o(mispred_cnt_o), .ret_cnt_o(ret_cnt_o)
  );

  function automatic logic [5:0] ctrl();
    return {F_stall_o, D_stall_o, D_bubble_o, E_bubble_o, M_bubble_o, W_stall_o};
  endfunction

  function automatic logic [31:0] pc(input logic [31:0] v);
    return PERF ? v : 32'h0;
  endfunction

  task automatic set_nop();
    D_icode_i = INOP; d_srcA_i = RNONE; d_srcB_i = RNONE;
    E_icode_i = INOP; E_dstM_i = RNONE; e_Cnd_i = 1'b1;
    m_stat_i = SAOK; W_stat_i = SAOK; cnt_clr_i = 1'b0;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    set_nop();
    rst_n_i = 1'b0;
    step();
    step();
    rst_n_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    set_nop();
    D_icode_i = IRET;
    #2;
    checks++;
    if (ctrl() !== 6'b101000) begin
      failures++; $display("FAIL reset_idle_outputs got=%b want=101000", ctrl());
    end
    checks++;
    if ({halted_o, stall_cnt_o, bubble_cnt_o, mispred_cnt_o, ret_cnt_o} !== 129'h0) begin
      failures++; $display("FAIL reset_state halted=%b stall=%h bubble=%h", halted_o, stall_cnt_o, bubble_cnt_o);
    end
    step();
    step();
    D_icode_i = INOP;
    rst_n_i = 1'b1;
    #2;
    checks++;
    if (ctrl() !== 6'b000000) begin
      failures++; $display("FAIL reset_release_idle got=%b want=000000", ctrl());
    end
    step();
    checks++;
    if (halted_o !== 1'b0 || ctrl() !== 6'b000000) begin
      failures++; $display("FAIL reset_first_edge halted=%b ctrl=%b want 0/000000", halted_o, ctrl());
    end
  endtask

  task automatic test_ret();
    logic [5:0] exp_seq [4];
    exp_seq[0] = 6'b101000; exp_seq[1] = 6'b101000;
    exp_seq[2] = 6'b101000; exp_seq[3] = 6'b000000;
    do_reset();
    D_icode_i = IRET;
    for (int c = 0; c < 4; c++) begin
      #2;
      checks++;
      if (ctrl() !== exp_seq[c]) begin
        failures++; $display("FAIL ret_cycle%0d got=%b want=%b", c, ctrl(), exp_seq[c]);
      end
      step();
      D_icode_i = INOP;
    end
    checks++;
    if (ret_cnt_o !== pc(32'd1) || stall_cnt_o !== pc(32'd3) || bubble_cnt_o !== pc(32'd3)) begin
      failures++; $display("FAIL ret_counters ret=%0d stall=%0d bubble=%0d want %0d/%0d/%0d",
                           ret_cnt_o, stall_cnt_o, bubble_cnt_o, pc(1), pc(3), pc(3));
    end
  endtask

  task automatic test_load_use();
    do_reset();
    E_icode_i = IMRMOVQ; E_dstM_i = 4'h3; d_srcA_i = 4'h3; D_icode_i = IRET;
    #2;
    checks++;
    if (ctrl() !== 6'b110100) begin
      failures++; $display("FAIL lu_mrmov got=%b want=110100", ctrl());
    end
    step();
    E_icode_i = INOP; E_dstM_i = RNONE; d_srcA_i = RNONE; D_icode_i = INOP;
    #2;
    checks++;
    if (ctrl() !== 6'b000000) begin
      failures++; $display("FAIL lu_no_ret_transition got=%b want=000000", ctrl());
    end
    E_icode_i = IPOPQ; E_dstM_i = 4'h6; d_srcB_i = 4'h6;
    #2;
    checks++;
    if (ctrl() !== 6'b110100) begin
      failures++; $display("FAIL lu_popq_srcB got=%b want=110100", ctrl());
    end
    E_icode_i = IMRMOVQ; E_dstM_i = RNONE; d_srcA_i = RNONE; d_srcB_i = RNONE;
    #2;
    checks++;
    if (ctrl() !== 6'b000000) begin
      failures++; $display("FAIL lu_rnone got=%b want=000000", ctrl());
    end
    E_icode_i = IRMMOVQ; E_dstM_i = 4'h2; d_srcA_i = 4'h2;
    #2;
    checks++;
    if (ctrl() !== 6'b000000) begin
      failures++; $display("FAIL lu_rmmov_no_hazard got=%b want=000000", ctrl());
    end
  endtask

  task automatic test_mispredict();
    do_reset();
    E_icode_i = IJXX; e_Cnd_i = 1'b0; D_icode_i = IRET;
    E_dstM_i = 4'h3; d_srcA_i = 4'h3;
    #2;
    checks++;
    if (ctrl() !== 6'b001100) begin
      failures++; $display("FAIL mp_over_ret got=%b want=001100", ctrl());
    end
    step();
    set_nop();
    #2;
    checks++;
    if (ctrl() !== 6'b000000) begin
      failures++; $display("FAIL mp_stays_idle got=%b want=000000", ctrl());
    end
    checks++;
    if (mispred_cnt_o !== pc(32'd1) || ret_cnt_o !== 32'h0) begin
      failures++; $display("FAIL mp_counters mispred=%0d ret=%0d want %0d/0", mispred_cnt_o, ret_cnt_o, pc(1));
    end
    E_icode_i = IJXX; e_Cnd_i = 1'b1;
    #2;
    checks++;
    if (ctrl() !== 6'b000000) begin
      failures++; $display("FAIL mp_taken_ok got=%b want=000000", ctrl());
    end
  endtask

  task automatic test_halt();
    do_reset();
    m_stat_i = SINS;
    #2;
    checks++;
    if (ctrl() !== 6'b000010) begin
      failures++; $display("FAIL m_stat_bubble got=%b want=000010", ctrl());
    end
    step();
    m_stat_i = SAOK;
    #2;
    checks++;
    if (halted_o !== 1'b0 || ctrl() !== 6'b000000) begin
      failures++; $display("FAIL m_stat_no_halt halted=%b ctrl=%b", halted_o, ctrl());
    end
    do_reset();
    D_icode_i = IRET;
    step();
    D_icode_i = INOP;
    step();
    W_stat_i = SADR;
    #2;
    checks++;
    if (ctrl() !== 6'b101011 || halted_o !== 1'b0) begin
      failures++; $display("FAIL halt_entry_cycle got=%b halted=%b want=101011/0", ctrl(), halted_o);
    end
    step();
    W_stat_i = SAOK;
    E_icode_i = IJXX; e_Cnd_i = 1'b0;
    #2;
    checks++;
    if (ctrl() !== 6'b110011 || halted_o !== 1'b1) begin
      failures++; $display("FAIL halt_outputs got=%b halted=%b want=110011/1", ctrl(), halted_o);
    end
    step(); step(); step();
    checks++;
    if (stall_cnt_o !== pc(32'd3) || bubble_cnt_o !== pc(32'd3) || mispred_cnt_o !== 32'h0 || ret_cnt_o !== pc(32'd1)) begin
      failures++; $display("FAIL halt_frozen stall=%0d bubble=%0d mp=%0d ret=%0d", stall_cnt_o, bubble_cnt_o, mispred_cnt_o, ret_cnt_o);
    end
    checks++;
    if (halted_o !== 1'b1) begin
      failures++; $display("FAIL halt_sticky halted=%b want=1", halted_o);
    end
    #2;
    rst_n_i = 1'b0;
    #1;
    checks++;
    if (halted_o !== 1'b0 || stall_cnt_o !== 32'h0 || ret_cnt_o !== 32'h0 || ctrl() !== 6'b001100) begin
      failures++; $display("FAIL halt_async_reset halted=%b stall=%0d ctrl=%b want 0/0/001100", halted_o, stall_cnt_o, ctrl());
    end
    step();
    set_nop();
    rst_n_i = 1'b1;
  endtask

  task automatic test_back_to_back();
    do_reset();
    D_icode_i = IRET;
    step();
    D_icode_i = INOP;
    step();
    step();
    D_icode_i = IRET;
    #2;
    checks++;
    if (ctrl() !== 6'b101000) begin
      failures++; $display("FAIL b2b_second_ret got=%b want=101000", ctrl());
    end
    step();
    D_icode_i = INOP;
    step();
    step();
    #2;
    checks++;
    if (ctrl() !== 6'b000000 || ret_cnt_o !== pc(32'd2) || stall_cnt_o !== pc(32'd6)) begin
      failures++; $display("FAIL b2b_end ctrl=%b ret=%0d stall=%0d want 000000/%0d/%0d", ctrl(), ret_cnt_o, stall_cnt_o, pc(2), pc(6));
    end
  endtask

  task automatic test_counters();
    do_reset();
    E_icode_i = IMRMOVQ; E_dstM_i = 4'h4; d_srcA_i = 4'h4;
    step(); step(); step();
    checks++;
    if (stall_cnt_o !== pc(32'd3) || bubble_cnt_o !== pc(32'd3)) begin
      failures++; $display("FAIL cnt_lu stall=%0d bubble=%0d want %0d", stall_cnt_o, bubble_cnt_o, pc(3));
    end
    cnt_clr_i = 1'b1;
    step();
    cnt_clr_i = 1'b0;
    checks++;
    if (stall_cnt_o !== 32'h0 || bubble_cnt_o !== 32'h0) begin
      failures++; $display("FAIL cnt_clear stall=%0d bubble=%0d want 0", stall_cnt_o, bubble_cnt_o);
    end
`ifdef PIPE_CTRL_PERF_CNT_EN
    force dut.g_cnt[0].cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.g_cnt[0].cnt_q;
    step(); step(); step();
    checks++;
    if (stall_cnt_o !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL cnt_saturate stall=%h want=ffffffff", stall_cnt_o);
    end
    cnt_clr_i = 1'b1;
    step();
    cnt_clr_i = 1'b0;
    checks++;
    if (stall_cnt_o !== 32'h0) begin
      failures++; $display("FAIL cnt_sat_clear stall=%h want=0", stall_cnt_o);
    end
`endif
    set_nop();
  endtask

  initial begin
    test_reset();
    test_ret();
    test_load_use();
    test_mispredict();
    test_halt();
    test_back_to_back();
    test_counters();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have ports: clk_i  in  1  pipeline clock; rst_n_i  in  1  asynchronous active-low reset; one clock domain, async assert, sync release via clk_i.
REQ-002 SHALL have inputs: D_icode_i 4 (decode icode); d_srcA_i 4; d_srcB_i 4; E_icode_i 4; E_dstM_i 4; e_Cnd_i 1 (execute condition); m_stat_i 4; W_stat_i 4; cnt_clr_i 1 (synchronous counter clear).
REQ-003 SHALL have outputs: F_stall_o, D_stall_o, D_bubble_o, E_bubble_o, M_bubble_o, W_stall_o, each 1 bit.
REQ-004 SHALL have outputs: halted_o 1 (sticky halt/exception); stall_cnt_o, bubble_cnt_o, mispred_cnt_o, ret_cnt_o, each 32 bits.
REQ-005 SHALL use icode, register (RNONE = 4'hF) and status (SAOK=1, SHLT=2, SADR=3, SINS=4) constants from define.v.

Function
REQ-006 SHALL contain a registered FSM: IDLE, RET_E, RET_M, HALT.
REQ-007 Load-use (LU) SHALL be E_icode in {IMRMOVQ, IPOPQ} and E_dstM_i != RNONE and E_dstM_i equal to d_srcA_i or d_srcB_i.
REQ-008 Mispredict (MP) SHALL be E_icode_i == IJXX and e_Cnd_i == 0.
REQ-009 In IDLE, MP SHALL assert D_bubble_o and E_bubble_o for that cycle; MP overrides ret and LU (no FSM transition, no stall).
REQ-010 In IDLE without MP, LU SHALL assert F_stall_o, D_stall_o, E_bubble_o; D_bubble_o stays 0; FSM stays IDLE even when D_icode_i == IRET.
REQ-011 In IDLE without MP or LU, D_icode_i == IRET SHALL assert F_stall_o and D_bubble_o and move FSM to RET_E; ret_cnt_o increments.
REQ-012 In RET_E and RET_M: F_stall_o=1, D_bubble_o=1; RET_E->RET_M->IDLE unconditionally, i.e. exactly 3 fetch-stall cycles per ret.
REQ-013 M_bubble_o SHALL be 1 whenever m_stat_i or W_stat_i != SAOK (any state).
REQ-014 W_stat_i != SAOK in any state SHALL move FSM to HALT next edge, abandoning any ret sequence; W_stall_o=1 that cycle.
REQ-015 In HALT: F_stall_o, D_stall_o, W_stall_o = 1, M_bubble_o = 1, D_bubble_o and E_bubble_o = 0; halted_o = 1; exit only by reset.
REQ-016 Stall and bubble outputs SHALL be combinational from FSM state and current inputs (zero-cycle latency); FSM and counters update on rising clk_i.
REQ-017 No output SHALL assert a stall and a bubble on the same stage simultaneously.
REQ-018 Counters: stall_cnt_o +1 per cycle with F_stall_o=1; bubble_cnt_o +1 per cycle with any of D/E/M bubble = 1; mispred_cnt_o +1 per MP cycle in IDLE; ret_cnt_o per REQ-011.
REQ-019 Counters SHALL saturate at 32'hFFFF_FFFF, freeze in HALT, and clear to 0 on cnt_clr_i=1 (clear wins over increment in the same cycle).

Reset
REQ-020 rst_n_i low SHALL immediately force FSM=IDLE, halted_o=0, all counters=0, including mid-ret-sequence and in HALT.
REQ-021 While in reset, outputs SHALL be IDLE-state functions of inputs; after release the first edge evaluates normally.

Configuration
REQ-022 Macro PIPE_CTRL_PERF_CNT_EN defined: counters of REQ-018/019 implemented.
REQ-023 Macro undefined: no counter flops; stall_cnt_o, bubble_cnt_o, mispred_cnt_o, ret_cnt_o tied to 32'h0; all control behaviour unchanged.

Verification
REQ-024 D_icode=IRET, others NOP, stat=SAOK -> F_stall=1 and D_bubble=1 for exactly 3 consecutive cycles, then 0; ret_cnt_o=1.
REQ-025 E_icode=IMRMOVQ, E_dstM=4'h3, d_srcA=4'h3 -> F_stall=D_stall=E_bubble=1, D_bubble=0; E_dstM=RNONE -> all 0.
REQ-026 E_icode=IJXX, e_Cnd=0, D_icode=IRET simultaneous -> D_bubble=E_bubble=1, F_stall=0, FSM stays IDLE, mispred_cnt_o=1, ret_cnt_o=0.
REQ-027 W_stat=SADR during RET_M -> M_bubble=W_stall=1 that cycle, next cycle HALT, halted_o=1, counters frozen; rst_n_i pulse low -> IDLE, counters 0.
REQ-028 Preload stall_cnt_o to 32'hFFFF_FFFE via stalls (or force), 3 further stall cycles -> holds 32'hFFFF_FFFF; cnt_clr_i=1 with stall -> 0.
REQ-029 Build without PIPE_CTRL_PERF_CNT_EN, rerun REQ-024 -> identical control outputs, all counters read 0.
